// File: rtl/lpc_synth.sv
// lpc_synth -- 10th-order LPC all-pole synthesis filter, one sample per request.
//
// Computes y[n] = sat16((e[n]*2^COEF_FRAC - sum_{k=1..10} A_k*y[n-k]) >>> COEF_FRAC)
// with one multiply per cycle. Excitation e[n] is a pitch pulse train (voiced)
// or +/-gain driven by a 16-bit Fibonacci LFSR (unvoiced).
//
// Ports:
//   d_clk    sample-domain clock, rising edge
//   rst      synchronous active-high reset
//   A1..A10  signed Q2.13 predictor coefficients (A0 = 1.0 implied)
//   voiced   1 = pulse excitation, 0 = noise excitation
//   pitch    pulse period in samples (effective minimum 2)
//   gain     signed excitation amplitude
//   load     strobe capturing A1..A10, voiced, pitch, gain as frame parameters
//   v        strobe requesting one output sample (accepted only when idle)
//   y        synthesized sample, held until the next vout
//   vout     one-cycle strobe, 13 cycles after the accepting v edge
//   busy     high while a sample is being computed
//   overrun  sticky: a v strobe arrived while busy and was dropped

module lpc_synth #(
    parameter int          COEF_FRAC = 13,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               d_clk,
    input  logic               rst,
    input  logic signed [15:0] A1,
    input  logic signed [15:0] A2,
    input  logic signed [15:0] A3,
    input  logic signed [15:0] A4,
    input  logic signed [15:0] A5,
    input  logic signed [15:0] A6,
    input  logic signed [15:0] A7,
    input  logic signed [15:0] A8,
    input  logic signed [15:0] A9,
    input  logic signed [15:0] A10,
    input  logic               voiced,
    input  logic        [15:0] pitch,
    input  logic signed [15:0] gain,
    input  logic               load,
    input  logic               v,
    output logic signed [15:0] y,
    output logic               vout,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, EXC, MAC, OUT} state_t;

    state_t state;

    // Active frame parameters and the pending copy captured while busy
    logic signed [15:0] a_q [10];
    logic signed [15:0] a_p [10];
    logic               voiced_q, voiced_p;
    logic        [15:0] pitch_q, pitch_p;
    logic signed [15:0] gain_q, gain_p;
    logic               pend;

    // hist[0] = y[n-1] ... hist[9] = y[n-10]
    logic signed [15:0] hist [10];
    logic        [3:0]  k;
    logic signed [39:0] acc;
    logic        [15:0] pcnt;
    logic        [15:0] lfsr;
    logic               out_pend;

    logic signed [15:0] a_in [10];
    logic signed [15:0] nxt_a [10];
    logic               nxt_voiced;
    logic        [15:0] nxt_pitch;
    logic signed [15:0] nxt_gain;
    logic signed [16:0] g_ext;
    logic signed [16:0] e;
    logic        [15:0] peff_m1;
    logic signed [31:0] prod;
    logic signed [39:0] acc_sh;
    logic signed [15:0] y_sat;
    logic               fb;

    always_comb begin
        a_in[0] = A1;
        a_in[1] = A2;
        a_in[2] = A3;
        a_in[3] = A4;
        a_in[4] = A5;
        a_in[5] = A6;
        a_in[6] = A7;
        a_in[7] = A8;
        a_in[8] = A9;
        a_in[9] = A10;
    end

    // A load arriving in IDLE overrides any older pending parameters
    always_comb begin
        if (load) begin
            nxt_a      = a_in;
            nxt_voiced = voiced;
            nxt_pitch  = pitch;
            nxt_gain   = gain;
        end else begin
            nxt_a      = a_p;
            nxt_voiced = voiced_p;
            nxt_pitch  = pitch_p;
            nxt_gain   = gain_p;
        end
    end

    always_comb begin
        g_ext   = {gain_q[15], gain_q};
        peff_m1 = (pitch_q < 16'd2) ? 16'd1 : pitch_q - 16'd1;
        if (voiced_q)
            e = (pcnt == '0) ? g_ext : '0;
        else
            e = lfsr[15] ? -g_ext : g_ext;
        prod   = a_q[k] * hist[k];
        acc_sh = acc >>> COEF_FRAC;
        if (acc_sh > 40'sd32767)
            y_sat = 16'sh7fff;
        else if (acc_sh < -40'sd32768)
            y_sat = 16'sh8000;
        else
            y_sat = acc_sh[15:0];
        fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end

    always_ff @(posedge d_clk) begin
        if (rst) begin
            state    <= IDLE;
            y        <= '0;
            vout     <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            pend     <= 1'b0;
            out_pend <= 1'b0;
            pcnt     <= '0;
            lfsr     <= LFSR_SEED;
            acc      <= '0;
            k        <= '0;
            voiced_q <= 1'b0;
            pitch_q  <= '0;
            gain_q   <= '0;
            voiced_p <= 1'b0;
            pitch_p  <= '0;
            gain_p   <= '0;
            for (int unsigned i = 0; i < 10; i++) begin
                hist[i] <= '0;
                a_q[i]  <= '0;
                a_p[i]  <= '0;
            end
        end else begin
            // Output stage one cycle after OUT: hist[0] already holds the saturated sample
            vout     <= out_pend;
            out_pend <= 1'b0;
            if (out_pend)
                y <= hist[0];

            if (v && state != IDLE)
                overrun <= 1'b1;

            if (load && state != IDLE) begin
                pend     <= 1'b1;
                a_p      <= a_in;
                voiced_p <= voiced;
                pitch_p  <= pitch;
                gain_p   <= gain;
            end

            case (state)
                IDLE: begin
                    if (load || pend) begin
                        a_q      <= nxt_a;
                        voiced_q <= nxt_voiced;
                        pitch_q  <= nxt_pitch;
                        gain_q   <= nxt_gain;
                        pend     <= 1'b0;
                        if (!voiced_q && nxt_voiced)
                            pcnt <= '0;
                    end
                    if (v) begin
                        state <= EXC;
                        busy  <= 1'b1;
                    end
                end
                EXC: begin
                    acc   <= {{23{e[16]}}, e} <<< COEF_FRAC;
                    pcnt  <= (pcnt >= peff_m1) ? '0 : pcnt + 16'd1;
                    lfsr  <= {lfsr[14:0], fb};
                    k     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc - {{8{prod[31]}}, prod};
                    k   <= k + 4'd1;
                    if (k == 4'd9)
                        state <= OUT;
                end
                OUT: begin
                    for (int unsigned i = 9; i > 0; i--)
                        hist[i] <= hist[i-1];
                    hist[0]  <= y_sat;
                    out_pend <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_synth.sv
module tb_lpc_synth;

    logic               d_clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] a_drv [10];
    logic               voiced = 1'b0;
    logic        [15:0] pitch = '0;
    logic signed [15:0] gain = '0;
    logic               load = 1'b0;
    logic               v = 1'b0;
    logic signed [15:0] y;
    logic               vout;
    logic               busy;
    logic               overrun;

    always #5 d_clk = ~d_clk;

    lpc_synth #(.COEF_FRAC(13), .LFSR_SEED(16'hACE1)) dut (
        .d_clk(d_clk), .rst(rst),
        .A1(a_drv[0]), .A2(a_drv[1]), .A3(a_drv[2]), .A4(a_drv[3]), .A5(a_drv[4]),
        .A6(a_drv[5]), .A7(a_drv[6]), .A8(a_drv[7]), .A9(a_drv[8]), .A10(a_drv[9]),
        .voiced(voiced), .pitch(pitch), .gain(gain), .load(load), .v(v),
        .y(y), .vout(vout), .busy(busy), .overrun(overrun)
    );

    typedef struct { int yv; int due; } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    bit armed = 0;

    // frame values the stimulus wants on the pins
    int s_a [10];
    bit s_voiced;
    int s_pitch, s_gain;

    // reference model state
    int m_a [10];
    bit m_voiced;
    int m_pitch, m_gain;
    bit m_pend;
    int p_a [10];
    bit p_voiced;
    int p_pitch, p_gain;
    int m_hist [10];
    int m_pc;
    logic [15:0] m_lfsr;
    bit m_ovr;
    int next_free;

    always @(posedge d_clk) edge_cnt++;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_a[i] = 0; p_a[i] = 0; m_hist[i] = 0;
        end
        m_voiced = 0; m_pitch = 0; m_gain = 0;
        p_voiced = 0; p_pitch = 0; p_gain = 0;
        m_pend = 0; m_pc = 0; m_lfsr = 16'hACE1; m_ovr = 0; next_free = 0;
    endtask

    // Behaviour at clock edge number t, given the inputs about to be sampled
    task automatic model_edge(int t, bit r, bit vv, bit ld);
        bit idle;
        int peff, e;
        longint s, ys;
        if (r) begin
            model_reset();
            while (q.size() > 0 && q[$].due >= t) void'(q.pop_back());
            return;
        end
        idle = (t >= next_free);
        if (vv && !idle) m_ovr = 1;
        if (idle && (ld || m_pend)) begin
            bit nv;
            nv = ld ? s_voiced : p_voiced;
            if (!m_voiced && nv) m_pc = 0;
            for (int i = 0; i < 10; i++) m_a[i] = ld ? s_a[i] : p_a[i];
            m_voiced = nv;
            m_pitch  = ld ? s_pitch : p_pitch;
            m_gain   = ld ? s_gain : p_gain;
            m_pend   = 0;
        end else if (!idle && ld) begin
            m_pend = 1;
            for (int i = 0; i < 10; i++) p_a[i] = s_a[i];
            p_voiced = s_voiced; p_pitch = s_pitch; p_gain = s_gain;
        end
        if (vv && idle) begin
            peff = (m_pitch < 2) ? 2 : m_pitch;
            if (m_voiced) e = (m_pc == 0) ? m_gain : 0;
            else          e = m_lfsr[15] ? -m_gain : m_gain;
            // pulse position within the period; a shrunken period restarts it
            if (m_pc + 1 >= peff) m_pc = 0;
            else                  m_pc = m_pc + 1;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            s = longint'(e) * 8192;
            for (int i = 0; i < 10; i++) s -= longint'(m_a[i]) * longint'(m_hist[i]);
            ys = s >>> 13;
            if (ys > 32767) ys = 32767;
            if (ys < -32768) ys = -32768;
            for (int i = 9; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = int'(ys);
            q.push_back('{yv: int'(ys), due: t + 13});
            next_free = t + 13;
        end
    endtask

    // One cycle of stimulus: check status so far, drive pins, advance the model
    task automatic cyc(bit r, bit vv, bit ld);
        @(negedge d_clk);
        if (armed) begin
            check("busy", busy, (edge_cnt < next_free - 1) ? 1 : 0);
            check("overrun", overrun, m_ovr);
        end
        rst = r; v = vv; load = ld;
        for (int i = 0; i < 10; i++) a_drv[i] = 16'(s_a[i]);
        voiced = s_voiced; pitch = 16'(s_pitch); gain = 16'(s_gain);
        model_edge(edge_cnt + 1, r, vv, ld);
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, 0, 0);
    endtask

    task automatic sample_every(int n, int gap);
        repeat (n) begin
            cyc(0, 1, 0);
            idle(gap - 1);
        end
    endtask

    task automatic set_frame(int a1, bit vc, int p, int g);
        for (int i = 0; i < 10; i++) s_a[i] = 0;
        s_a[0] = a1; s_voiced = vc; s_pitch = p; s_gain = g;
    endtask

    // Wait through the edge following the last cyc, then look at the outputs
    task automatic check_after_edge(string tag);
        @(posedge d_clk);
        #1;
        check({tag, "_y"}, y, 0);
        check({tag, "_vout"}, vout, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Scoreboard monitor
    always @(negedge d_clk) begin
        if (armed && vout) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vout: got vout=1 y=%0d expected no output (edge %0d)", y, edge_cnt);
            end else begin
                exp_t ex;
                ex = q.pop_front();
                n_chk--;
                check("y", y, ex.yv);
                check("vout_time", edge_cnt, ex.due);
            end
        end
    end

    initial begin
        for (int i = 0; i < 10; i++) a_drv[i] = '0;
        set_frame(0, 0, 0, 0);
        model_reset();
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        armed = 1;
        check_after_edge("reset");
        check("reset_overrun", overrun, 0);

        // pulse train, period 4
        set_frame(0, 1, 4, 1000);
        cyc(0, 0, 1);
        sample_every(8, 20);

        // first-order decay
        cyc(1, 0, 0);
        set_frame(-4096, 1, 100, 8192);
        cyc(0, 0, 1);
        sample_every(15, 14);

        // saturation at the maximum request rate
        cyc(1, 0, 0);
        set_frame(-8192, 1, 2, 20000);
        cyc(0, 0, 1);
        sample_every(6, 13);

        // noise excitation
        cyc(1, 0, 0);
        set_frame(0, 0, 0, 500);
        cyc(0, 0, 1);
        sample_every(20, 15);

        // dropped v and load while busy
        cyc(1, 0, 0);
        set_frame(0, 1, 3, 1000);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        idle(2);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        set_frame(0, 1, 3, -2000);
        cyc(0, 0, 1);
        idle(20);
        check("overrun_set", overrun, 1);
        sample_every(3, 14);

        // reset in the middle of a computation
        cyc(1, 0, 0);
        set_frame(0, 1, 3, 1000);
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        idle(6);
        cyc(1, 0, 0);
        check_after_edge("midrst");
        set_frame(-4096, 1, 3, 1000);
        cyc(0, 0, 1);
        sample_every(3, 14);

        // randomized traffic
        cyc(1, 0, 0);
        for (int n = 0; n < 1500; n++) begin
            bit rv, rl, rr;
            for (int i = 0; i < 10; i++) s_a[i] = int'($urandom_range(0, 4096)) - 2048;
            s_voiced = $urandom_range(0, 1);
            s_pitch  = $urandom_range(0, 6);
            s_gain   = int'($urandom_range(0, 65535)) - 32768;
            rv = ($urandom_range(0, 7) == 0);
            rl = ($urandom_range(0, 19) == 0);
            rr = ($urandom_range(0, 399) == 0);
            cyc(rr, rv, rl);
        end
        idle(20);

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_vout: got %0d outstanding samples expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
